rom_read_arbiter: RTL and testbench
===================================

# rom_read_arbiter

Round-robin read arbiter and burst sequencer that shares one combinational ROM (ADDR_WIDTH address in, DATA_WIDTH data out, zero-latency) between two requesters. Each requester issues a start address and a beat count. The arbiter grants one requester at a time, steps the ROM address once per cycle, and returns registered read data with a valid and last-beat marker. It sits between the ROM and the two consumer blocks; the ROM itself stays purely combinational.

## Interface
- ADDR_WIDTH, 12, ROM address width
- DATA_WIDTH, 8, ROM data width
- LEN_WIDTH, 4, burst length field width; a burst is len+1 beats

Ports:
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- req_0 / req_1  input  1  read request from requester 0 / 1, level
- addr_0 / addr_1  input  ADDR_WIDTH  burst start address
- len_0 / len_1  input  LEN_WIDTH  burst beats minus one
- gnt_0 / gnt_1  output  1  one-cycle grant pulse; addr/len are captured
- rvalid_0 / rvalid_1  output  1  read data valid for requester 0 / 1
- rdata  output  DATA_WIDTH  shared registered read data
- rlast  output  1  final beat of the current burst, qualified by rvalid_x
- busy  output  1  high while a burst is in progress
- rom_addr  output  ADDR_WIDTH  address to the ROM
- rom_data  input  DATA_WIDTH  ROM read data for rom_addr, same cycle

## Operation
- States: IDLE and BURST.
- Registers: state, cur_addr, remaining (LEN_WIDTH), owner (1 bit), prio pointer (1 bit).
- IDLE: sample req_0 and req_1 on each edge.
  - Only one requester high: that requester wins.
  - Both high: the requester equal to prio wins.
  - On a win: gnt_owner<=1, cur_addr<=addr_owner, remaining<=len_owner, owner<=winner, state<=BURST.
  - No request: stay in IDLE.
- BURST, on every edge:
  - rdata<=rom_data, rvalid_owner<=1, rlast<=(remaining==0).
  - cur_addr<=cur_addr+1, modulo 2^ADDR_WIDTH; wraps 0xFFF to 0x000 at the default width.
  - If remaining==0: state<=IDLE, prio<=~owner. Otherwise remaining<=remaining-1.
- rom_addr = cur_addr in all states; in IDLE it holds its last value.
- busy = (state==BURST).
- gnt_x is high for exactly the first BURST cycle. rvalid_x is never high for the non-owner.
- No backpressure: consumers must accept one beat per cycle.
- Requester protocol: hold req, addr and len stable until gnt is seen; changes before the grant are don't-care. A req still high when the arbiter returns to IDLE is treated as a new request.
- Reset values: state=IDLE, prio=0, owner=0, cur_addr=0, remaining=0. All outputs 0: gnt_x, rvalid_x, rdata, rlast, busy, and rom_addr.
- Reset asserted mid-burst: the burst is abandoned immediately and asynchronously. No further beats are produced, and the burst is not resumed after release.

## Timing
- Request sampled in IDLE at edge N:
  - gnt_x and busy are high in cycle N+1.
  - rom_addr equals the start address in cycle N+1.
- Beat k (k=0..len) is valid in cycle N+2+k. Its data is rom_data at address start+k.
- rlast is high with beat len only.
- busy falls after edge N+len+1; state is IDLE in cycle N+len+2.
- The next grant is issued at the earliest at edge N+len+2, so there is exactly one idle cycle between back-to-back bursts.
- rvalid of the final beat (cycle N+len+2) overlaps the IDLE cycle.
- Peak throughput is (len+1)/(len+2) beats per cycle.

## Test plan
The bench ROM contents are: 0x000..0x004 = 0x00..0x04, 0x005 = 0xFF, 0x006 = 0x05, all other addresses = 0xFF.
- Reset: hold rst_n=0 with random inputs -> every output is 0. Release, no req -> outputs stay 0 and busy=0.
- Single burst: req_0=1, addr_0=0x002, len_0=3, sampled at edge N -> gnt_0 is high in cycle N+1 only. rvalid_0 is high in cycles N+2..N+5 with rdata 0x02, 0x03, 0x04, 0xFF. rlast only in N+5. rvalid_1 stays 0.
- Contention and round-robin: both req high from reset with addr_0=0x000, len_0=0 and addr_1=0x006, len_1=0.
  - Requester 0 is served first -> rdata 0x00 on rvalid_0.
  - Requester 1 is served next -> rdata 0x05 on rvalid_1.
  - Both held high -> grants alternate 0, 1, 0, 1 with one idle cycle between bursts.
- Wrap-around: req_1, addr_1=0xFFF, len_1=1 -> rom_addr is 0xFFF then 0x000. rvalid_1 data is 0xFF then 0x00, with rlast on the second beat.
- Reset mid-burst: req_0, addr_0=0x000, len_0=7; assert rst_n=0 during the cycle of beat 2.
  - Required immediately: rvalid_0=0, busy=0, rlast=0, rom_addr=0x000.
  - After release with req low: no further beats.
  - Re-request -> the burst restarts from beat 0 with data 0x00.

Source files
------------

// File: rtl/rom_read_arbiter_if.sv
// rtl/rom_read_arbiter_if.sv - requester/ROM bus bundle for rom_read_arbiter
//   master: requesters and ROM side (drives req/addr/len and rom_data)
//   slave : the arbiter (drives gnt, rvalid, rdata, rlast, busy, rom_addr)
interface rom_read_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic                  req_0;
    logic                  req_1;
    logic [ADDR_WIDTH-1:0] addr_0;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [LEN_WIDTH-1:0]  len_0;
    logic [LEN_WIDTH-1:0]  len_1;
    logic                  gnt_0;
    logic                  gnt_1;
    logic                  rvalid_0;
    logic                  rvalid_1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;

    modport master (
        output req_0, req_1, addr_0, addr_1, len_0, len_1, rom_data,
        input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata, rlast, busy, rom_addr
    );

    modport slave (
        input  req_0, req_1, addr_0, addr_1, len_0, len_1, rom_data,
        output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata, rlast, busy, rom_addr
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - round-robin two-requester burst reader for a combinational ROM
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : req/addr/len in, gnt/rvalid/rdata/rlast/busy out, rom_addr out, rom_data in
module rom_read_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rom_read_arbiter_if.slave    bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  owner;
    logic                  prio;
    logic                  win;

    // With a single request that requester wins; with both, prio decides.
    always_comb begin
        win = bus.req_1;
        if (bus.req_0 && bus.req_1) begin
            win = prio;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_addr     <= '0;
            remaining    <= '0;
            owner        <= 1'b0;
            prio         <= 1'b0;
            bus.gnt_0    <= 1'b0;
            bus.gnt_1    <= 1'b0;
            bus.rvalid_0 <= 1'b0;
            bus.rvalid_1 <= 1'b0;
            bus.rdata    <= '0;
            bus.rlast    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The last beat's rvalid overlaps this cycle; clear it here.
                    bus.rvalid_0 <= 1'b0;
                    bus.rvalid_1 <= 1'b0;
                    bus.rlast    <= 1'b0;
                    if (bus.req_0 || bus.req_1) begin
                        bus.gnt_0 <= ~win;
                        bus.gnt_1 <= win;
                        cur_addr  <= win ? bus.addr_1 : bus.addr_0;
                        remaining <= win ? bus.len_1 : bus.len_0;
                        owner     <= win;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    bus.gnt_0    <= 1'b0;
                    bus.gnt_1    <= 1'b0;
                    bus.rdata    <= bus.rom_data;
                    bus.rvalid_0 <= ~owner;
                    bus.rvalid_1 <= owner;
                    bus.rlast    <= (remaining == '0);
                    cur_addr     <= cur_addr + ADDR_WIDTH'(1);
                    if (remaining == '0) begin
                        state <= IDLE;
                        prio  <= ~owner;
                    end else begin
                        remaining <= remaining - LEN_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == BURST);
    assign bus.rom_addr = cur_addr;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - scoreboard bench for rom_read_arbiter
module tb_rom_read_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;
    logic prio_m = 1'b0;

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;
    beat_t exp_q[$];

    rom_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    rom_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        if (a <= 12'h004) return DW'(a);
        if (a == 12'h006) return 8'h05;
        return 8'hFF;
    endfunction

    assign bus.rom_data = rom(bus.rom_addr);

    function automatic logic [AW+DW+6-1:0] outs();
        return {bus.gnt_0, bus.gnt_1, bus.rvalid_0, bus.rvalid_1, bus.rdata,
                bus.rlast, bus.busy, bus.rom_addr};
    endfunction

    // Monitor: every presented beat is popped and compared, including its cycle.
    logic gnt_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.rvalid_0 || bus.rvalid_1) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_beat cyc=%0d rv0=%b rv1=%b rdata=%02h required none",
                         cyc, bus.rvalid_0, bus.rvalid_1, bus.rdata);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (bus.rvalid_0 == bus.rvalid_1 || bus.rvalid_1 != e.owner ||
                    bus.rdata != e.data || bus.rlast != e.last || cyc != e.cyc) begin
                    errs++;
                    $display("FAIL beat got rv0=%b rv1=%b data=%02h last=%b cyc=%0d required owner=%0d data=%02h last=%b cyc=%0d",
                             bus.rvalid_0, bus.rvalid_1, bus.rdata, bus.rlast, cyc,
                             e.owner, e.data, e.last, e.cyc);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            vecs++;
            errs++;
            $display("FAIL missing_beat cyc=%0d got no rvalid required beat due at cyc=%0d",
                     cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (bus.gnt_0 || bus.gnt_1) begin
            vecs++;
            if (gnt_prev) begin
                errs++;
                $display("FAIL gnt_width got gnt high two cycles required one-cycle pulse");
            end
        end
        gnt_prev = bus.gnt_0 | bus.gnt_1;
    end

    task automatic issue(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        if (i == 0) begin
            bus.req_0 = 1'b1; bus.addr_0 = a; bus.len_0 = l;
        end else begin
            bus.req_1 = 1'b1; bus.addr_1 = a; bus.len_1 = l;
        end
    endtask

    // Call at a negedge; expects the next grant after exp_gap cycles (-1: unchecked).
    task automatic wait_grant(input int exp_gap, output int w_len);
        int            n;
        int            exp_w;
        int            w;
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        exp_w = (bus.req_0 && bus.req_1) ? int'(prio_m) : (bus.req_0 ? 0 : 1);
        n = 1;
        @(negedge clk);
        while (!(bus.gnt_0 || bus.gnt_1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        w_len = 0;
        vecs++;
        if (!(bus.gnt_0 || bus.gnt_1)) begin
            errs++;
            $display("FAIL grant_timeout got no gnt in %0d cycles required gnt", n);
            return;
        end
        w = bus.gnt_1 ? 1 : 0;
        a = w ? bus.addr_1 : bus.addr_0;
        l = w ? bus.len_1 : bus.len_0;
        if ((bus.gnt_0 && bus.gnt_1) || w != exp_w || (exp_gap >= 0 && n != exp_gap) ||
            bus.rom_addr != a || !bus.busy) begin
            errs++;
            $display("FAIL grant got winner=%0d both=%b gap=%0d rom_addr=%03h busy=%b required winner=%0d gap=%0d rom_addr=%03h busy=1",
                     w, bus.gnt_0 & bus.gnt_1, n, bus.rom_addr, bus.busy, exp_w, exp_gap, a);
        end
        for (int k = 0; k <= int'(l); k++) begin
            beat_t e;
            e.owner = w[0];
            e.data  = rom(a + AW'(k));
            e.last  = (k == int'(l));
            e.cyc   = cyc + 1 + k;
            exp_q.push_back(e);
        end
        prio_m = ~w[0];
        if (w == 0) bus.req_0 = 1'b0; else bus.req_1 = 1'b0;
        w_len = int'(l);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL drain_timeout got %0d beats outstanding required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int l;
        bus.req_0 = 0; bus.req_1 = 0;
        bus.addr_0 = '0; bus.addr_1 = '0; bus.len_0 = '0; bus.len_1 = '0;

        // Reset with random inputs, then idle after release.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.req_0 = 1'($urandom); bus.req_1 = 1'($urandom);
            bus.addr_0 = AW'($urandom); bus.addr_1 = AW'($urandom);
            bus.len_0 = LW'($urandom); bus.len_1 = LW'($urandom);
            #1;
            vecs++;
            if (outs() != '0) begin
                errs++;
                $display("FAIL reset_outputs got %h required 0", outs());
            end
        end
        @(negedge clk);
        bus.req_0 = 0; bus.req_1 = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++;
            if (outs() != '0) begin
                errs++;
                $display("FAIL idle_outputs got %h required 0", outs());
            end
        end

        // Single burst from 0x002, four beats.
        issue(0, 12'h002, 4'd3);
        wait_grant(1, l);
        drain();

        // Contention from reset: alternating zero-length bursts.
        rst_n = 1'b0;
        prio_m = 1'b0;
        issue(0, 12'h000, 4'd0);
        issue(1, 12'h006, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant(1, l);
        for (int i = 0; i < 6; i++) begin
            if (!bus.req_0) issue(0, 12'h000, 4'd0);
            if (!bus.req_1) issue(1, 12'h006, 4'd0);
            wait_grant(l + 2, l);
        end
        bus.req_0 = 0; bus.req_1 = 0;
        drain();

        // Wrap-around at the top of the address space.
        issue(1, 12'hFFF, 4'd1);
        wait_grant(1, l);
        drain();

        // Randomized back-to-back traffic.
        issue(int'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), LW'($urandom));
        wait_grant(1, l);
        for (int i = 0; i < 40; i++) begin
            if (!bus.req_0 && $urandom_range(0, 1) == 1)
                issue(0, ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)), LW'($urandom));
            if (!bus.req_1 && $urandom_range(0, 1) == 1)
                issue(1, ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)), LW'($urandom));
            if (!bus.req_0 && !bus.req_1)
                issue(int'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), LW'($urandom));
            wait_grant(l + 2, l);
        end
        bus.req_0 = 0; bus.req_1 = 0;
        drain();

        // Reset asserted during beat 2 of an eight-beat burst.
        issue(0, 12'h000, 4'd7);
        wait_grant(1, l);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_0 = 1'b0;
        exp_q.delete();
        prio_m = 1'b0;
        #1;
        vecs++;
        if (bus.rvalid_0 || bus.busy || bus.rlast || bus.rom_addr != '0) begin
            errs++;
            $display("FAIL reset_midburst got rv0=%b busy=%b rlast=%b rom_addr=%03h required 0,0,0,000",
                     bus.rvalid_0, bus.busy, bus.rlast, bus.rom_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(0, 12'h000, 4'd7);
        wait_grant(1, l);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
